// File: rtl/m_clk_gate_ctrl_pkg.sv
// Shared definitions for the clock-gate controller: state encoding,
// default timing parameters and the wake-counter width.
package m_clk_pkg;

  localparam int STATE_W      = 2;
  localparam int IDLE_CYC_DEF = 16;
  localparam int WAKE_CYC_DEF = 2;
  localparam int WAKE_CNT_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    S_OFF   = 2'd0,
    S_WAKE  = 2'd1,
    S_ON    = 2'd2,
    S_DRAIN = 2'd3
  } gate_state_e;

  // Every state except OFF needs the gated clock running.
  function automatic logic state_enables_clk(gate_state_e s);
    return (s != S_OFF);
  endfunction

endpackage

// File: rtl/m_clk_gate_ctrl_if.sv
// Consumer <-> controller handshake bundle. The consumer (master) drives
// req/busy/force_on; the controller (slave) returns clk_en/ack/state_o.
interface m_clk_gate_ctrl_if;
  import m_clk_pkg::*;

  logic               req;
  logic               busy;
  logic               force_on;
  logic               clk_en;
  logic               ack;
  logic [STATE_W-1:0] state_o;

  modport master (
    output req, busy, force_on,
    input  clk_en, ack, state_o
  );

  modport slave (
    input  req, busy, force_on,
    output clk_en, ack, state_o
  );

endinterface

// File: rtl/m_clk_gate_ctrl_sat_cnt.sv
// Saturating up-counter: clr has priority, inc stops at MAX (never wraps).
module m_sat_cnt #(
  parameter int WIDTH = 4,
  parameter int MAX   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear wins, otherwise step up until pinned at MAX.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX_V)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/m_clk_gate_ctrl.sv
// Clock-gate controller. Sequences OFF -> WAKE -> ON -> DRAIN -> OFF and
// produces a registered enable for the parent's clock-gate cell plus a
// registered ack telling the consumer the gated clock is usable.
// IDLE_CYC legal 1..255, WAKE_CYC legal 1..15.
module m_clk_gate_ctrl
  import m_clk_pkg::*;
#(
  parameter int IDLE_CYC = IDLE_CYC_DEF,
  parameter int WAKE_CYC = WAKE_CYC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  m_clk_gate_ctrl_if.slave bus
);

  localparam int IDLE_W = $clog2(IDLE_CYC + 1);
  // Transitions fire on the last counted cycle so that the new state's
  // registered outputs line up with the cycle counts seen by the consumer.
  localparam logic [IDLE_W-1:0]     IDLE_LAST = IDLE_W'(IDLE_CYC - 1);
  localparam logic [WAKE_CNT_W-1:0] WAKE_LAST = WAKE_CNT_W'(WAKE_CYC - 1);

  gate_state_e state_q;
  gate_state_e state_d;
  logic        clk_en_q;
  logic        clk_en_d;
  logic        ack_q;
  logic        ack_d;

  logic                  activity;
  logic                  wake_clr;
  logic                  wake_inc;
  logic                  idle_clr;
  logic                  idle_inc;
  logic [WAKE_CNT_W-1:0] wake_cnt;
  logic [IDLE_W-1:0]     idle_cnt;

  assign activity = bus.req | bus.busy;

  // Wake counter runs only while in WAKE; held at 0 everywhere else so it
  // is already loaded with 0 on entry.
  assign wake_clr = (state_q != S_WAKE);
  assign wake_inc = (state_q == S_WAKE);

  // Idle counter runs only in ON; any req/busy cycle restarts it.
  assign idle_clr = (state_q != S_ON) | activity;
  assign idle_inc = (state_q == S_ON);

  m_sat_cnt #(
    .WIDTH (WAKE_CNT_W),
    .MAX   ((1 << WAKE_CNT_W) - 1)
  ) u_wake_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wake_clr),
    .inc   (wake_inc),
    .count (wake_cnt)
  );

  m_sat_cnt #(
    .WIDTH (IDLE_W),
    .MAX   (IDLE_CYC)
  ) u_idle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (idle_clr),
    .inc   (idle_inc),
    .count (idle_cnt)
  );

  // Next-state decode plus the output values that go with the next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_OFF:   if (bus.req) state_d = S_WAKE;
      S_WAKE:  if (wake_cnt == WAKE_LAST) state_d = S_ON;
      S_ON:    if (!activity && (idle_cnt == IDLE_LAST)) state_d = S_DRAIN;
      S_DRAIN: state_d = activity ? S_ON : S_OFF;
      default: state_d = S_OFF;
    endcase
    // Enable stays high through DRAIN, so it can never fall while ack is high.
    clk_en_d = state_enables_clk(state_d) | bus.force_on;
    ack_d    = (state_d == S_ON);
  end

  // State and output flops; reset forces everything off even under force_on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_OFF;
      clk_en_q <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      clk_en_q <= clk_en_d;
      ack_q    <= ack_d;
    end
  end

  assign bus.clk_en  = clk_en_q;
  assign bus.ack     = ack_q;
  assign bus.state_o = state_q;

endmodule

// File: doc/m_clk_gate_ctrl.md
M_CLK_GATE_CTRL -- requirements
Module: m_clk_gate_ctrl

Interface
REQ-001 SHALL have parameter IDLE_CYC, default 16, meaning idle cycles in ON before clock is gated (legal 1..255).
REQ-002 SHALL have parameter WAKE_CYC, default 2, meaning cycles from clk_en rise to ack (legal 1..15).
REQ-003 SHALL have port clk  input  1  free-running clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  1  consumer requests gated clock; level, held until ack seen.
REQ-006 SHALL have port busy  input  1  consumer activity; any high cycle restarts the idle count.
REQ-007 SHALL have port force_on  input  1  debug override; clock enabled regardless of state.
REQ-008 SHALL have port clk_en  output  1  enable to the tech clock-gate/OR cell; registered.
REQ-009 SHALL have port ack  output  1  gated clock stable and usable; registered.
REQ-010 SHALL have port state_o  output  2  current FSM state encoding.

Function
REQ-011 SHALL implement FSM states OFF=0, WAKE=1, ON=2, DRAIN=3.
REQ-012 OFF: clk_en=force_on, ack=0; req=1 -> WAKE next cycle, wake counter loaded 0.
REQ-013 WAKE: clk_en=1, ack=0; counter increments each cycle; at count WAKE_CYC-1 -> ON, so ack rises exactly WAKE_CYC cycles after clk_en rises.
REQ-014 ON: clk_en=1, ack=1; idle counter cleared on any cycle with req|busy; else increments; reaching IDLE_CYC -> DRAIN.
REQ-015 DRAIN: clk_en=1, ack=0 for exactly one cycle; then -> OFF with clk_en=0 (unless force_on), so enable never drops while ack=1.
REQ-016 req or busy high during DRAIN SHALL return to ON next cycle (ack re-asserts, no WAKE delay).
REQ-017 req high in same cycle OFF is entered SHALL be honoured: OFF lasts one cycle, then WAKE.
REQ-018 force_on=1 SHALL hold clk_en=1 in every state and block DRAIN->OFF transition gating only (FSM still transitions; ack follows FSM).
REQ-019 Idle counter SHALL saturate at IDLE_CYC; width clog2(IDLE_CYC+1); wake counter width 4; no wrap-around.
REQ-020 clk_en and ack SHALL be flop outputs, glitch-free, changing only on clk rising edge.
REQ-021 state_o SHALL equal the registered state every cycle.

Reset
REQ-022 rst_n low SHALL asynchronously force state OFF, clk_en=0, ack=0, both counters 0.
REQ-023 Release of rst_n SHALL take effect on the next rising clk; reset mid-WAKE or mid-ON SHALL drop clk_en and ack immediately with no DRAIN cycle.
REQ-024 force_on SHALL NOT override reset: clk_en=0 while rst_n=0.

Structure
REQ-025 State encoding constants and the default IDLE_CYC/WAKE_CYC values SHALL live in shared package m_clk_pkg.
REQ-026 The saturating up-counter SHALL be one sub-module m_sat_cnt (parameter width, inputs clr/inc, output count), instantiated twice.
REQ-027 The block SHALL contain no clock-gating cells; clk_en drives the technology-wrapped gate instantiated by the parent.

Verification
REQ-028 Reset then req=1 at cycle 5 -> state WAKE cycle 6, clk_en=1 cycle 6, ack=1 cycle 8 (WAKE_CYC=2).
REQ-029 ON, req=busy=0 for 16 cycles -> DRAIN on cycle 17 with ack=0, OFF and clk_en=0 on cycle 18.
REQ-030 ON, idle 15 cycles then busy=1 one cycle -> idle count clears, no DRAIN; gating occurs 16 idle cycles later.
REQ-031 busy=1 during DRAIN -> ON next cycle, ack=1, clk_en never low.
REQ-032 force_on=1 through full idle timeout -> state reaches OFF, clk_en stays 1, ack=0.
REQ-033 rst_n pulsed low mid-WAKE (between edges) -> clk_en and ack 0 immediately, state_o=0; after release, req re-wakes with full WAKE_CYC latency.
